countdown_timer: RTL

Programmable down-counter (timer) that consumes a count. It complements the team's free-running 4-bit up-counter. A start value is loaded through a valid/ready handshake, then decremented on each enabled clock. A one-cycle done pulse fires on expiry, with optional automatic reload. It is used wherever a block needs "wait N enabled cycles, then act".

---
 rtl/countdown_pkg.sv | 14 +
 rtl/countdown_timer_down_counter.sv | 28 ++
 rtl/countdown_timer.sv | 118 +++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer.
// Holds the FSM state encoding, default width and statistics width.
package countdown_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int EXP_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_timer_down_counter.sv
// Loadable WIDTH-bit down counter with synchronous reset.
// Ports: clock, reset, load/value, dec -> count, is_one.
module down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             is_one
);

  // load has priority over dec
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec) begin
      count <= count - WIDTH'(1);
    end
  end

  assign is_one = (count == WIDTH'(1));

endmodule

// File: rtl/countdown_timer.sv
// Programmable down-counter with load handshake and done pulse.
// Ports: clock/reset, load_*, enable, abort -> count_out, flags, done, expire_cnt.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] count_out,
  output logic             busy,
  output logic             paused,
  output logic             done,
  output logic [EXP_W-1:0] expire_cnt
);

  state_t           state;
  logic [WIDTH-1:0] reload;
  logic             accept;
  logic             zero_load;
  logic             active;
  logic             expire;
  logic             is_one;
  logic             cnt_load;
  logic             cnt_dec;
  logic [WIDTH-1:0] cnt_value;

  assign accept    = load_valid && (state == ST_IDLE);
  assign zero_load = (load_value == '0);
  assign active    = (state == ST_RUN) || (state == ST_PAUSE);
  assign expire    = active && enable && !abort && is_one;

  assign load_ready = (state == ST_IDLE);
  assign busy       = active;
  assign paused     = (state == ST_PAUSE);

  // Counter control; the arms are mutually exclusive.
  always_comb begin
    cnt_load  = 1'b0;
    cnt_value = '0;
    cnt_dec   = 1'b0;
    unique case (1'b1)
      accept: begin
        cnt_load  = 1'b1;
        cnt_value = load_value;
      end
      active && abort: begin
        cnt_load = 1'b1;
      end
      expire: begin
        cnt_load  = 1'b1;
        cnt_value = AUTO_RELOAD ? reload : '0;
      end
      active && enable && !abort && !is_one: begin
        cnt_dec = 1'b1;
      end
      default: ;
    endcase
  end

  down_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clock (clock),
    .reset (reset),
    .load  (cnt_load),
    .value (cnt_value),
    .dec   (cnt_dec),
    .count (count_out),
    .is_one(is_one)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      done       <= 1'b0;
      expire_cnt <= '0;
      reload     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            reload <= load_value;
            if (zero_load) begin
              // zero-length timer expires without leaving IDLE
              done       <= 1'b1;
              expire_cnt <= expire_cnt + EXP_W'(1);
            end else begin
              state <= enable ? ST_RUN : ST_PAUSE;
            end
          end
        end
        ST_RUN, ST_PAUSE: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (!enable) begin
            state <= ST_PAUSE;
          end else if (is_one) begin
            done       <= 1'b1;
            expire_cnt <= expire_cnt + EXP_W'(1);
            state      <= AUTO_RELOAD ? ST_RUN : ST_IDLE;
          end else begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
